// File: rtl/spi_pt_pkg.sv
// Shared types and field positions for the housekeeping SPI pass-thru router.
package spi_pt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_PASS   = 2'd2,
        ST_IGNORE = 2'd3
    } pt_state_e;

    localparam int unsigned CMD_HI_MSB = 7;
    localparam int unsigned CMD_HI_LSB = 4;
    localparam int unsigned CMD_CH_MSB = 3;
    localparam int unsigned CMD_CH_LSB = 1;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned BYTE_CNT_W = 16;

    // Pass-thru when the high nibble matches the base, bit 0 is clear and the channel exists.
    function automatic logic is_pt_cmd(input logic [7:0] cmd, input logic [7:0] base,
                                       input int unsigned nch, input logic en);
        return en
            && (cmd[CMD_HI_MSB:CMD_HI_LSB] == base[CMD_HI_MSB:CMD_HI_LSB])
            && !cmd[0]
            && (32'(cmd[CMD_CH_MSB:CMD_CH_LSB]) < nch);
    endfunction

endpackage

// File: rtl/spi_pt_sync.sv
// N-stage synchroniser for an asynchronous input, with single-clock edge pulses.
module spi_pt_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_pass_thru_router.sv
// Housekeeping SPI front end: decodes the first host byte and either bridges the
// host to one downstream SPI channel or hands the opcode to housekeeping.
module spi_pass_thru_router
    import spi_pt_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter logic [7:0]  CMD_BASE    = 8'hC0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_CH    = 0
) (
    input  logic                  clock,
    input  logic                  resetb,
    input  logic                  host_csb,
    input  logic                  host_sck,
    input  logic                  host_sdi,
    output logic                  host_sdo,
    output logic                  host_sdo_oe,
    input  logic                  enable,
    output logic [NCH-1:0]        ch_csb,
    output logic [NCH-1:0]        ch_sck,
    output logic [NCH-1:0]        ch_sdo,
    output logic [NCH-1:0]        ch_oe,
    input  logic [NCH-1:0]        ch_sdi,
    output logic [7:0]            hk_cmd,
    output logic                  hk_cmd_valid,
    output logic                  pt_active,
    output logic [CH_W-1:0]       pt_channel,
    output logic                  cpu_reset_req,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    logic           unused_csb_lvl, unused_sdi_rise, unused_sdi_fall;
    logic           csb_rise_c, csb_fall_c, sck_s, sck_rise_c, sck_fall_c, sdi_s;
    logic [NCH-1:0] ch_sdi_s, unused_ch_rise, unused_ch_fall;

    spi_pt_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk(clock), .rst_n(resetb), .d_i(host_csb),
        .q_o(unused_csb_lvl), .rise_c(csb_rise_c), .fall_c(csb_fall_c));
    spi_pt_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clock), .rst_n(resetb), .d_i(host_sck),
        .q_o(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c));
    spi_pt_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clock), .rst_n(resetb), .d_i(host_sdi),
        .q_o(sdi_s), .rise_c(unused_sdi_rise), .fall_c(unused_sdi_fall));

    for (genvar g = 0; g < NCH; g++) begin : g_ch_sync
        spi_pt_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ch (
            .clk(clock), .rst_n(resetb), .d_i(ch_sdi[g]),
            .q_o(ch_sdi_s[g]), .rise_c(unused_ch_rise[g]), .fall_c(unused_ch_fall[g]));
    end

    pt_state_e             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [CH_W-1:0]       pt_channel_q, chan_d;
    logic [7:0]            hk_cmd_q, hk_cmd_d;
    logic                  hk_cmd_valid_q, hk_cmd_valid_d;
    logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
    logic [NCH-1:0]        ch_csb_q, ch_csb_d, ch_sck_q, ch_sck_d;
    logic [NCH-1:0]        ch_sdo_q, ch_sdo_d, ch_oe_q, ch_oe_d;
    logic                  host_sdo_q, host_sdo_d, host_sdo_oe_q, pt_active_q, pass_c;
    logic                  cpu_reset_req_q, cpu_reset_req_d;
    logic [7:0]            cmd_c;
    logic [MAX_CH-1:0]     sel_oh_c, sdi_pad_c;
    logic [NCH-1:0]        sel_c;

    assign sdi_pad_c = MAX_CH'(ch_sdi_s);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            pt_channel_q    <= '0;
            hk_cmd_q        <= '0;
            hk_cmd_valid_q  <= 1'b0;
            byte_count_q    <= '0;
            ch_csb_q        <= '1;
            ch_sck_q        <= '0;
            ch_sdo_q        <= '0;
            ch_oe_q         <= '0;
            host_sdo_q      <= 1'b0;
            host_sdo_oe_q   <= 1'b0;
            pt_active_q     <= 1'b0;
            cpu_reset_req_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            pt_channel_q    <= chan_d;
            hk_cmd_q        <= hk_cmd_d;
            hk_cmd_valid_q  <= hk_cmd_valid_d;
            byte_count_q    <= byte_count_d;
            ch_csb_q        <= ch_csb_d;
            ch_sck_q        <= ch_sck_d;
            ch_sdo_q        <= ch_sdo_d;
            ch_oe_q         <= ch_oe_d;
            host_sdo_q      <= host_sdo_d;
            host_sdo_oe_q   <= pass_c;
            pt_active_q     <= pass_c;
            cpu_reset_req_q <= cpu_reset_req_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        chan_d         = pt_channel_q;
        hk_cmd_d       = hk_cmd_q;
        hk_cmd_valid_d = 1'b0;
        byte_count_d   = byte_count_q;
        cmd_c          = {shift_q, sdi_s};

        // csb release (or enable loss while bridging) tears the channel down on this clock
        if (csb_rise_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall_c) begin
                        state_d      = ST_CMD;
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                        byte_count_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_c) begin
                        shift_d   = cmd_c[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (is_pt_cmd(cmd_c, CMD_BASE, NCH, enable)) begin
                                state_d = ST_PASS;
                                chan_d  = cmd_c[CMD_CH_MSB:CMD_CH_LSB];
                            end else begin
                                state_d        = ST_IGNORE;
                                hk_cmd_d       = cmd_c;
                                hk_cmd_valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    if (!enable) begin
                        state_d = ST_IGNORE;
                    end else if (sck_rise_c) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if ((bit_cnt_q == 3'd7) && (byte_count_q != '1)) begin
                            byte_count_d = byte_count_q + BYTE_CNT_W'(1);
                        end
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // channel outputs follow the next state so teardown and entry are registered together
        pass_c          = (state_d == ST_PASS);
        sel_oh_c        = MAX_CH'(1) << chan_d;
        sel_c           = sel_oh_c[NCH-1:0];
        ch_csb_d        = '1;
        ch_sck_d        = '0;
        ch_sdo_d        = '0;
        ch_oe_d         = '0;
        host_sdo_d      = 1'b0;
        cpu_reset_req_d = pass_c && (RESET_CH < NCH) && (32'(chan_d) == RESET_CH);
        if (pass_c) begin
            ch_csb_d   = sck_fall_c ? ~sel_c : ch_csb_q;
            ch_sck_d   = sel_c & {NCH{sck_s}};
            ch_sdo_d   = sel_c & {NCH{sdi_s}};
            ch_oe_d    = sel_c;
            host_sdo_d = sdi_pad_c[chan_d];
        end
    end

    assign host_sdo      = host_sdo_q;
    assign host_sdo_oe   = host_sdo_oe_q;
    assign ch_csb        = ch_csb_q;
    assign ch_sck        = ch_sck_q;
    assign ch_sdo        = ch_sdo_q;
    assign ch_oe         = ch_oe_q;
    assign hk_cmd        = hk_cmd_q;
    assign hk_cmd_valid  = hk_cmd_valid_q;
    assign pt_active     = pt_active_q;
    assign pt_channel    = pt_channel_q;
    assign cpu_reset_req = cpu_reset_req_q;
    assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_spi_pass_thru_router.sv
// Directed bench for spi_pass_thru_router with a channel-1 SPI flash model and
// scoreboard queues for housekeeping opcodes and read-back data.
`timescale 1ns/1ps
module tb_spi_pass_thru_router;

    localparam int NCH  = 2;
    localparam int SS   = 2;
    localparam int HALF = 10;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        host_csb = 1'b1, host_sck = 1'b0, host_sdi = 1'b0, enable = 1'b1;
    logic        host_sdo, host_sdo_oe;
    logic [1:0]  ch_csb, ch_sck, ch_sdo, ch_oe, ch_sdi;
    logic [7:0]  hk_cmd;
    logic        hk_cmd_valid, pt_active, cpu_reset_req;
    logic [2:0]  pt_channel;
    logic [15:0] byte_count;

    always #5 clock = ~clock;

    spi_pass_thru_router #(.NCH(NCH), .CMD_BASE(8'hC0), .SYNC_STAGES(SS), .RESET_CH(0)) dut (
        .clock(clock), .resetb(resetb),
        .host_csb(host_csb), .host_sck(host_sck), .host_sdi(host_sdi),
        .host_sdo(host_sdo), .host_sdo_oe(host_sdo_oe), .enable(enable),
        .ch_csb(ch_csb), .ch_sck(ch_sck), .ch_sdo(ch_sdo), .ch_oe(ch_oe), .ch_sdi(ch_sdi),
        .hk_cmd(hk_cmd), .hk_cmd_valid(hk_cmd_valid), .pt_active(pt_active),
        .pt_channel(pt_channel), .cpu_reset_req(cpu_reset_req), .byte_count(byte_count));

    int total = 0;
    int bad   = 0;
    logic [7:0] hk_exp_q[$];
    logic [7:0] rd_exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel-1 flash: mode-0 READ (0x03 + 24-bit address), data shifted out on falling sck.
    logic [7:0]  fl_mem [0:255];
    logic [31:0] fl_sr = '0;
    int          fl_cnt = 0;
    logic        fl_sck_p = 1'b0, fl_out = 1'b0;
    logic [7:0]  fl_byte = '0;
    initial begin
        for (int i = 0; i < 256; i++) fl_mem[i] = 8'hFF;
        fl_mem[0] = 8'h6F;
    end
    always @(posedge clock) begin
        fl_sck_p <= ch_sck[1];
        if (ch_csb[1] !== 1'b0) begin
            fl_cnt <= 0;
            fl_out <= 1'b0;
        end else begin
            if (ch_sck[1] && !fl_sck_p) begin
                fl_sr  <= {fl_sr[30:0], ch_sdo[1]};
                fl_cnt <= fl_cnt + 1;
            end
            if (!ch_sck[1] && fl_sck_p && fl_cnt >= 32) begin
                if (fl_cnt == 32) begin
                    fl_out  <= (fl_sr[31:24] == 8'h03) ? fl_mem[fl_sr[7:0]][7] : 1'b1;
                    fl_byte <= (fl_sr[31:24] == 8'h03) ? {fl_mem[fl_sr[7:0]][6:0], 1'b1} : 8'hFF;
                end else begin
                    fl_out  <= fl_byte[7];
                    fl_byte <= {fl_byte[6:0], 1'b1};
                end
            end
        end
    end
    assign ch_sdi = {fl_out, 1'b0};

    // Monitors: housekeeping scoreboard plus activity/cpu-hold counters.
    logic hk_prev = 1'b0;
    int   act_cnt = 0, pt_cnt = 0, c0_low_cnt = 0, rr_bad = 0, rr_hi = 0;
    always @(negedge clock) begin
        logic [31:0] e;
        hk_prev <= hk_cmd_valid;
        if (ch_csb !== 2'b11 || ch_sck !== 2'b00 || ch_oe !== 2'b00) act_cnt <= act_cnt + 1;
        if (pt_active === 1'b1) pt_cnt <= pt_cnt + 1;
        if (ch_csb[0] === 1'b0) c0_low_cnt <= c0_low_cnt + 1;
        if (cpu_reset_req !== (pt_active && pt_channel == 3'd0)) rr_bad <= rr_bad + 1;
        if (cpu_reset_req === 1'b1) rr_hi <= rr_hi + 1;
        if (hk_cmd_valid === 1'b1) begin
            chk("hk_valid_single", 32'(hk_prev), 32'd0);
            if (hk_exp_q.size() > 0) e = 32'(hk_exp_q.pop_front());
            else e = 32'h100;
            chk("hk_cmd_scoreboard", 32'(hk_cmd), e);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            host_sdi = tx[7-i];
            wait_clks(HALF);
            host_sck = 1'b1;
            rx = {rx[6:0], host_sdo};
            wait_clks(HALF);
            host_sck = 1'b0;
        end
    endtask

    task automatic txn2(input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] rx;
        host_csb = 1'b0;
        wait_clks(HALF);
        spi_bits(b0, 8, rx);
        spi_bits(b1, 8, rx);
        wait_clks(HALF);
        host_csb = 1'b1;
        wait_clks(2 * HALF);
    endtask

    initial begin
        logic [7:0] rx;
        int a0, p0, r0, h0;

        // reset state
        wait_clks(4);
        chk("rst_ch_csb", 32'(ch_csb), 32'h3);
        chk("rst_ch_sck", 32'(ch_sck), 32'h0);
        chk("rst_ch_oe", 32'(ch_oe), 32'h0);
        chk("rst_ch_sdo", 32'(ch_sdo), 32'h0);
        chk("rst_sdo_oe", 32'(host_sdo_oe), 32'h0);
        chk("rst_hk", 32'({hk_cmd, hk_cmd_valid}), 32'h0);
        chk("rst_pt", 32'({pt_active, pt_channel, cpu_reset_req}), 32'h0);
        chk("rst_byte_count", 32'(byte_count), 32'h0);
        resetb = 1'b1;
        wait_clks(5);

        // flash read through channel 1
        a0 = c0_low_cnt;
        rd_exp_q.push_back(8'h6F);
        host_csb = 1'b0;
        wait_clks(HALF);
        spi_bits(8'hC2, 8, rx);
        chk("pass_entry_active", 32'(pt_active), 32'h1);
        chk("csb_waits_for_sck_fall", 32'(ch_csb), 32'h3);
        wait_clks(SS + 1);
        chk("csb1_low", 32'(ch_csb), 32'h1);
        chk("sdo_oe_in_pass", 32'(host_sdo_oe), 32'h1);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        chk("read_data", 32'(rx), 32'(rd_exp_q.pop_front()));
        wait_clks(HALF);
        host_csb = 1'b1;
        wait_clks(2 * HALF);
        chk("read_pt_active_off", 32'(pt_active), 32'h0);
        chk("read_pt_channel", 32'(pt_channel), 32'h1);
        chk("read_byte_count", 32'(byte_count), 32'd5);
        chk("read_csb_idle", 32'(ch_csb), 32'h3);
        chk("read_ch0_untouched", 32'(c0_low_cnt - a0), 32'd0);

        // housekeeping command
        a0 = act_cnt; p0 = pt_cnt;
        hk_exp_q.push_back(8'h40);
        txn2(8'h40, 8'h03);
        chk("hk40_cmd", 32'(hk_cmd), 32'h40);
        chk("hk40_no_ch_activity", 32'(act_cnt - a0), 32'd0);
        chk("hk40_no_pass", 32'(pt_cnt - p0), 32'd0);

        // channel 0 pass-thru asserts cpu hold
        r0 = rr_bad; h0 = rr_hi; p0 = pt_cnt;
        txn2(8'hC0, 8'hFF);
        chk("c0_reset_req_tracks_pass", 32'(rr_bad - r0), 32'd0);
        chk("c0_reset_req_cycles", 32'(rr_hi - h0), 32'(pt_cnt - p0));
        chk("c0_reset_req_seen", 32'((rr_hi - h0) > 0), 32'd1);
        chk("c0_pt_channel", 32'(pt_channel), 32'h0);
        chk("c0_byte_count", 32'(byte_count), 32'd1);

        // partial byte then early csb release
        host_csb = 1'b0;
        wait_clks(HALF);
        spi_bits(8'hC2, 8, rx);
        spi_bits(8'hA0, 3, rx);
        wait_clks(HALF);
        chk("partial_csb1_low", 32'(ch_csb), 32'h1);
        host_csb = 1'b1;
        wait_clks(SS);
        chk("csb_rise_not_early", 32'(ch_csb[1]), 32'h0);
        wait_clks(1);
        chk("csb_rise_latency", 32'(ch_csb), 32'h3);
        chk("partial_byte_count", 32'(byte_count), 32'd0);
        wait_clks(2 * HALF);
        hk_exp_q.push_back(8'h40);
        txn2(8'h40, 8'h00);
        chk("after_partial_hk", 32'(hk_cmd), 32'h40);

        // disabled pass-thru and out-of-range channel
        a0 = act_cnt; p0 = pt_cnt;
        enable = 1'b0;
        hk_exp_q.push_back(8'hC2);
        txn2(8'hC2, 8'h00);
        chk("disabled_hk", 32'(hk_cmd), 32'hC2);
        enable = 1'b1;
        hk_exp_q.push_back(8'hCE);
        txn2(8'hCE, 8'h00);
        chk("range_hk", 32'(hk_cmd), 32'hCE);
        chk("no_select_activity", 32'(act_cnt - a0), 32'd0);
        chk("no_select_pass", 32'(pt_cnt - p0), 32'd0);

        // asynchronous reset mid-pass
        host_csb = 1'b0;
        wait_clks(HALF);
        spi_bits(8'hC2, 8, rx);
        spi_bits(8'h03, 8, rx);
        chk("mid_pass_active", 32'(pt_active), 32'h1);
        chk("mid_pass_byte_count", 32'(byte_count), 32'd1);
        host_sck = 1'b1;
        wait_clks(SS + 2);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_ch", 32'({ch_csb, ch_sck, ch_sdo, ch_oe}), 32'hC0);
        chk("arst_host", 32'({host_sdo, host_sdo_oe}), 32'h0);
        chk("arst_pt", 32'({pt_active, pt_channel, cpu_reset_req}), 32'h0);
        chk("arst_byte_count", 32'(byte_count), 32'h0);
        host_csb = 1'b1;
        host_sck = 1'b0;
        wait_clks(3);
        resetb = 1'b1;
        wait_clks(5);
        chk("post_reset_idle", 32'({ch_csb, pt_active}), 32'h6);
        chk("hk_queue_drained", 32'(hk_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
